// File: rtl/dot_product_stream_if.sv
`default_nettype none
// ============================================================================
// Module      : dot_product_stream_if
// Description : Streaming port bundle for dot_product_stream. It carries the
//               input beat handshake, the result handshake and the sideband
//               controls.
//               The master modport is the producer/consumer side, which
//               drives beats and accepts results. The slave modport is the
//               engine side.
// Ports       : in_valid / in_ready       - input beat handshake
//               filterInput / imageInput  - LANES packed DATA_W elements,
//                                           lane k at [k*DATA_W +: DATA_W]
//               is_signed                 - operand mode, taken on first beat
//               flush                     - abort the partial vector
//               out_valid / out_ready     - result handshake
//               out_data                  - ACC_W result
//               busy                      - partial vector in progress
// Revision    : 1.0 - initial release
// ============================================================================
interface dot_product_stream_if #(
  parameter int DATA_W = 8,
  parameter int LANES  = 1,
  parameter int ACC_W  = 19
) ();

  logic                      in_valid;
  logic                      in_ready;
  logic [LANES*DATA_W-1:0]   filterInput;
  logic [LANES*DATA_W-1:0]   imageInput;
  logic                      is_signed;
  logic                      flush;
  logic                      out_valid;
  logic                      out_ready;
  logic [ACC_W-1:0]          out_data;
  logic                      busy;

  // Producer/consumer side: offers beats and takes results.
  modport master (
    output in_valid,
    output filterInput,
    output imageInput,
    output is_signed,
    output flush,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  busy
  );

  // Engine side.
  modport slave (
    input  in_valid,
    input  filterInput,
    input  imageInput,
    input  is_signed,
    input  flush,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output busy
  );

endinterface
`default_nettype wire

// File: rtl/dot_product_stream.sv
`default_nettype none
// ============================================================================
// Module      : dot_product_stream
// Description : Streaming dot-product engine. Each accepted beat carries LANES
//               filter/image element pairs. The lane products are summed by an
//               adder tree and then accumulated over SIZE/LANES beats. One
//               ACC_W result is emitted per vector on a valid/ready port.
//               Operands are zero- or sign-extended according to is_signed,
//               which is latched on the first beat of each vector.
//               The result appears one cycle after the final beat. The next
//               vector may start on the very next cycle.
// Ports       : clk   - rising-edge clock
//               reset - asynchronous active-low reset. Release is delayed by
//                       one internal synchroniser flop.
//               bus   - dot_product_stream_if.slave (beats, result, flush,
//                       is_signed, busy)
// Parameters  : DATA_W - operand width
//               SIZE   - elements per vector. Must be a multiple of LANES.
//               LANES  - element pairs per beat
//               ACC_W  - result width. At the default it cannot overflow.
//                        A smaller override wraps modulo 2^ACC_W.
// Option      : DOT_PRODUCT_RELU_EN - when defined, a signed vector whose
//               final sum is negative produces 0. Unsigned results are
//               unaffected. Latency does not change.
// Revision    : 1.0 - initial release
// ============================================================================
module dot_product_stream #(
  parameter int DATA_W = 8,
  parameter int SIZE   = 8,
  parameter int LANES  = 1,
  parameter int ACC_W  = 2*DATA_W + $clog2(SIZE)
) (
  input  wire logic           clk,
  input  wire logic           reset,
  dot_product_stream_if.slave bus
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int c_beats  = SIZE / LANES;
  localparam int c_cnt_w  = (c_beats > 1) ? $clog2(c_beats) : 1;
  localparam logic [c_cnt_w-1:0] c_last_beat = c_cnt_w'(c_beats - 1);
  // The adder tree is built as a heap over a power-of-two leaf count.
  // Leaves beyond LANES are tied to zero.
  localparam int c_tree_n = 1 << $clog2(LANES);

  // --------------------------------------------------------------------------
  // Reset release synchroniser
  // --------------------------------------------------------------------------
  // Assertion is passed straight through, so all state clears immediately.
  // Release reaches the datapath only on the next clock edge, which gives the
  // one-cycle deassert delay. in_ready is also held low by this flop, so no
  // beat can be taken while the engine is still in reset.
  logic r_rst_sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rst_sync <= 1'b0;
    end else begin
      r_rst_sync <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  // The operating states are implicit in these registers:
  //   idle  : r_beat_cnt == 0 and r_out_valid == 0
  //   accum : r_beat_cnt != 0
  //   hold  : r_out_valid == 1 (may coexist with accum)
  logic [c_cnt_w-1:0] r_beat_cnt;
  logic [ACC_W-1:0]   r_acc;
  logic               r_signed;
  logic               r_out_valid;
  logic [ACC_W-1:0]   r_out_data;

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
  logic w_first;
  logic w_last;
  logic w_hold_stall;
  logic w_in_ready;
  logic w_accept;
  logic w_mode;

  assign w_first      = (r_beat_cnt == '0);
  assign w_last       = (r_beat_cnt == c_last_beat);
  // Input stalls only while a finished result is waiting for the consumer.
  assign w_hold_stall = r_out_valid && !bus.out_ready;
  // A beat offered during a flush cycle is dropped along with the partial
  // vector, so it is never accepted.
  assign w_in_ready   = r_rst_sync && !w_hold_stall && !bus.flush;
  assign w_accept     = bus.in_valid && w_in_ready;

  // On the first beat, the operands must be extended using the mode being
  // latched in the same cycle, so the live input is used. Later beats use
  // the latched copy, which makes mid-vector changes of is_signed harmless.
  assign w_mode = w_first ? bus.is_signed : r_signed;

  // --------------------------------------------------------------------------
  // Lane multipliers and adder tree
  // --------------------------------------------------------------------------
  logic [ACC_W-1:0] w_node [2*c_tree_n-1];

  for (genvar k = 0; k < c_tree_n; k++) begin : g_leaf
    if (k < LANES) begin : g_lane
      logic [DATA_W-1:0] w_f;
      logic [DATA_W-1:0] w_i;
      logic [ACC_W-1:0]  w_fx;
      logic [ACC_W-1:0]  w_ix;

      assign w_f  = bus.filterInput[k*DATA_W +: DATA_W];
      assign w_i  = bus.imageInput[k*DATA_W +: DATA_W];
      // Extend both operands to the full result width before multiplying.
      // The product is then already correct modulo 2^ACC_W for both modes.
      assign w_fx = w_mode ? ACC_W'($signed(w_f)) : ACC_W'(w_f);
      assign w_ix = w_mode ? ACC_W'($signed(w_i)) : ACC_W'(w_i);
      assign w_node[c_tree_n-1+k] = w_fx * w_ix;
    end else begin : g_pad
      assign w_node[c_tree_n-1+k] = '0;
    end
  end

  // Internal node n sums its two children 2n+1 and 2n+2. Node 0 is the root.
  for (genvar n = 0; n < c_tree_n - 1; n++) begin : g_node
    assign w_node[n] = w_node[2*n+1] + w_node[2*n+2];
  end

  logic [ACC_W-1:0] w_beat_sum;
  logic [ACC_W-1:0] w_total;
  logic [ACC_W-1:0] w_result;

  assign w_beat_sum = w_node[0];
  // The first beat loads rather than adds, so there is no residue from the
  // previous vector. This also covers the case of a single beat per vector.
  assign w_total    = w_first ? w_beat_sum : (r_acc + w_beat_sum);

`ifdef DOT_PRODUCT_RELU_EN
  // Clamp negative signed results. Unsigned sums pass through unchanged.
  assign w_result = (w_mode && w_total[ACC_W-1]) ? '0 : w_total;
`else
  assign w_result = w_total;
`endif

  // --------------------------------------------------------------------------
  // Accumulator, beat counter and mode latch
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge r_rst_sync) begin
    if (!r_rst_sync) begin
      r_beat_cnt <= '0;
      r_acc      <= '0;
      r_signed   <= 1'b0;
    end else if (bus.flush) begin
      r_beat_cnt <= '0;
      r_acc      <= '0;
    end else if (w_accept) begin
      r_acc <= w_total;
      if (w_first) begin
        r_signed <= bus.is_signed;
      end
      if (w_last) begin
        r_beat_cnt <= '0;
      end else begin
        r_beat_cnt <= r_beat_cnt + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Result register
  // --------------------------------------------------------------------------
  // A final beat can only be accepted while the held result is being taken.
  // In that case the new result overwrites the old one in the same cycle and
  // out_valid stays high. Otherwise the hold is dropped on handshake.
  // out_data keeps its last value after a handshake. Flush never touches it.
  always_ff @(posedge clk or negedge r_rst_sync) begin
    if (!r_rst_sync) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_accept && w_last) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_result;
    end else if (r_out_valid && bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.busy      = (r_beat_cnt != '0);

endmodule
`default_nettype wire
